entry_ctrl: RTL and testbench
=============================

ENTRY_CTRL -- requirements
Module: entry_ctrl

Interface
REQ-001 Parameters SHALL be:
- DB_CYCLES, default 4: cycles a synchronised button level must stay stable before it is accepted.
- MAX_TRIES, default 3: confirms allowed without an intervening unlock_ok.
- LOCK_CYCLES, default 16: lockout duration in cycles.
REQ-002 Ports SHALL be:
- CLK  in  1  sole clock; all logic on the rising edge.
- RST  in  1  synchronous, active-low reset.
- btn_confirm  in  1  raw, asynchronous confirm button.
- btn_request  in  1  raw, asynchronous request button.
- sw_pass  in  4  password switches.
- sw_din  in  4  data switches.
- unlock_ok  in  1  one-cycle pulse from the downstream FSM: password accepted.
- confirm  out  1  one-cycle pulse, registered.
- request  out  1  one-cycle pulse, registered.
- pass_data  out  4  sw_pass captured at confirm.
- din  out  4  sw_din captured at request.
- locked  out  1  high while in lockout.
- tries  out  2  confirms issued since the last clear.

Function
REQ-003 Each button SHALL pass through a 2-flop synchroniser, then a debouncer.
REQ-004 Debouncer counter behaviour:
- Counter SHALL increment while the synchronised level differs from the debounced level.
- Counter SHALL clear when the two levels are equal.
- When the count reaches DB_CYCLES-1 and the levels still differ, the debounced level SHALL toggle and the counter SHALL clear.
REQ-005 A 0->1 transition of the debounced level SHALL produce a one-cycle pulse on the corresponding output. 1->0 transitions SHALL produce nothing.
REQ-006 Pulse latency: given a raw input that goes high and stays high, the pulse SHALL appear exactly 2+DB_CYCLES cycles after the first edge that samples it high.
REQ-007 Glitch rejection: a raw high shorter than DB_CYCLES synchronised cycles SHALL produce no pulse.
REQ-008 pass_data SHALL load sw_pass on the same edge that asserts confirm, and SHALL hold otherwise.
REQ-009 din SHALL load sw_din on the same edge that asserts request, and SHALL hold otherwise.
REQ-010 Control FSM states: OPEN and LOCKED.
REQ-011 In OPEN:
- Each issued confirm SHALL increment tries.
- unlock_ok SHALL clear tries to 0.
- If unlock_ok and confirm coincide, tries SHALL become 1.
REQ-012 In OPEN, a confirm pulse generated while tries == MAX_TRIES and unlock_ok is low SHALL NOT be issued. On that cycle the block SHALL:
- transition to LOCKED,
- load the lock timer with LOCK_CYCLES-1,
- assert locked from the next edge.
REQ-013 In LOCKED:
- confirm and request SHALL be suppressed.
- pass_data and din SHALL hold.
- unlock_ok SHALL be ignored.
- The timer SHALL decrement every cycle.
REQ-014 When the lock timer reaches 0, the next edge SHALL transition to OPEN, clear tries and deassert locked. Total locked time SHALL be exactly LOCK_CYCLES cycles.
REQ-015 Debouncers SHALL keep running during LOCKED. A button already debounced high at unlock SHALL produce no pulse until it is released and pressed again.
REQ-016 The two buttons SHALL be independent. Simultaneous confirm and request pulses SHALL both be issued in OPEN.
REQ-017 The tries counter SHALL saturate at MAX_TRIES and never wrap.

Reset
REQ-018 While RST is low at a clock edge:
- confirm, request, locked, tries, pass_data and din SHALL be 0.
- The FSM SHALL be OPEN.
- Synchronisers, debounced levels, debounce counters and the lock timer SHALL be 0.
REQ-019 Reset SHALL take effect mid-debounce or mid-lockout with no residual pulse.
REQ-020 A button held through reset release SHALL generate a single pulse 2+DB_CYCLES cycles after the first post-reset edge.

Structure
REQ-021 Package entry_pkg SHALL hold:
- the state enum (OPEN, LOCKED),
- default values for DB_CYCLES, MAX_TRIES and LOCK_CYCLES,
- the timer width derived via $clog2(LOCK_CYCLES).
REQ-022 Sub-module debouncer (synchroniser + counter + rising-edge detect, DB_CYCLES parameter) SHALL be instantiated twice.

Verification
REQ-023 Hold btn_confirm high with sw_pass=4'hA from cycle 10 -> confirm pulses at cycle 16 only, pass_data=4'hA, tries=1.
REQ-024 btn_request high for 2 cycles -> no request pulse, din unchanged.
REQ-025 Four confirm presses without unlock_ok -> three confirm pulses, tries=3. Fourth press: no pulse, locked=1 for exactly 16 cycles, then tries=0.
REQ-026 unlock_ok on the same cycle as the 2nd confirm pulse -> tries=1. Further presses reach lockout only after 3 more.
REQ-027 Pull RST low mid-lockout and mid-debounce -> next cycle all outputs 0, state OPEN, no pulse after release unless a button is held.
REQ-028 Press both buttons on the same cycle in OPEN -> confirm and request pulse on the same cycle; pass_data and din both captured.

Source files
------------

// File: rtl/entry_pkg.sv
// Shared types and defaults for the entry controller: FSM states, parameter
// defaults and the lock-timer width helper.
package entry_pkg;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DB_CYCLES_DEF   = 4;
  localparam int MAX_TRIES_DEF   = 3;
  localparam int LOCK_CYCLES_DEF = 16;

  localparam int TMR_W_DEF = $clog2(LOCK_CYCLES_DEF);

  // Timer width for a given lockout length; never narrower than one bit.
  function automatic int tmr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Button front end: 2-flop synchroniser, stability counter and rising-edge
// detect. rise_o is high for the single cycle after the debounced level rises.
module debouncer #(
  parameter int DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          db_q, db_dly_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      db_dly_q <= db_q;
      if (s2_q != db_q) begin
        if (cnt_q == CW'(DB_CYCLES - 1)) begin
          db_q  <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rise_o = db_q & ~db_dly_q;

endmodule

// File: rtl/entry_ctrl.sv
// Entry controller: debounced confirm/request buttons with data capture, a
// tries counter and a timed lockout after too many confirms.
module entry_ctrl
  import entry_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int MAX_TRIES   = MAX_TRIES_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       btn_confirm,
  input  logic       btn_request,
  input  logic [3:0] sw_pass,
  input  logic [3:0] sw_din,
  input  logic       unlock_ok,
  output logic       confirm,
  output logic       request,
  output logic [3:0] pass_data,
  output logic [3:0] din,
  output logic       locked,
  output logic [1:0] tries
);

  localparam int TW = tmr_w(LOCK_CYCLES);

  logic conf_rise, req_rise;

  debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_conf (
    .CLK    (CLK),
    .RST    (RST),
    .btn_i  (btn_confirm),
    .rise_o (conf_rise)
  );

  debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_req (
    .CLK    (CLK),
    .RST    (RST),
    .btn_i  (btn_request),
    .rise_o (req_rise)
  );

  state_e          state_q, state_d;
  logic [1:0]      tries_q, tries_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            confirm_q, confirm_d;
  logic            request_q, request_d;
  logic [3:0]      pass_q, pass_d;
  logic [3:0]      din_q, din_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= OPEN;
      tries_q   <= '0;
      tmr_q     <= '0;
      confirm_q <= 1'b0;
      request_q <= 1'b0;
      pass_q    <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      tmr_q     <= tmr_d;
      confirm_q <= confirm_d;
      request_q <= request_d;
      pass_q    <= pass_d;
      din_q     <= din_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    tmr_d     = tmr_q;
    confirm_d = 1'b0;
    request_d = 1'b0;
    pass_d    = pass_q;
    din_d     = din_q;
    case (state_q)
      OPEN: begin
        request_d = req_rise;
        if (req_rise) din_d = sw_din;
        // A confirm past the limit is swallowed and starts the lockout instead.
        if (conf_rise && (tries_q == 2'(MAX_TRIES)) && !unlock_ok) begin
          state_d = LOCKED;
          tmr_d   = TW'(LOCK_CYCLES - 1);
        end else begin
          confirm_d = conf_rise;
          if (conf_rise) pass_d = sw_pass;
          if (unlock_ok)
            tries_d = conf_rise ? 2'd1 : 2'd0;
          else if (conf_rise && (tries_q < 2'(MAX_TRIES)))
            tries_d = tries_q + 2'd1;
        end
      end
      LOCKED: begin
        if (tmr_q == '0) begin
          state_d = OPEN;
          tries_d = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = OPEN;
    endcase
  end

  assign confirm   = confirm_q;
  assign request   = request_q;
  assign pass_data = pass_q;
  assign din       = din_q;
  assign locked    = (state_q == LOCKED);
  assign tries     = tries_q;

endmodule

// File: tb/tb_entry_ctrl.sv
// Scoreboard bench for entry_ctrl: expected pulses are queued when buttons are
// driven and matched against confirm/request as they appear.
module tb_entry_ctrl;

  localparam int DB  = 4;
  localparam int MT  = 3;
  localparam int LK  = 16;
  localparam int LAT = DB + 3;  // drive negedge -> negedge where the pulse is seen

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       btn_confirm = 1'b0, btn_request = 1'b0, unlock_ok = 1'b0;
  logic [3:0] sw_pass = '0, sw_din = '0;
  logic       confirm, request, locked;
  logic [3:0] pass_data, din;
  logic [1:0] tries;

  entry_ctrl #(.DB_CYCLES(DB), .MAX_TRIES(MT), .LOCK_CYCLES(LK)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .btn_confirm (btn_confirm),
    .btn_request (btn_request),
    .sw_pass     (sw_pass),
    .sw_din      (sw_din),
    .unlock_ok   (unlock_ok),
    .confirm     (confirm),
    .request     (request),
    .pass_data   (pass_data),
    .din         (din),
    .locked      (locked),
    .tries       (tries)
  );

  typedef struct {
    int cyc;
    int data;
    int tries;
  } exp_t;

  exp_t cq[$];
  exp_t rq[$];
  exp_t me;
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   lk_lo = 0, lk_hi = 0;
  int   m_tries = 0;
  bit   mon_en = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (confirm === 1'b1) begin
        if (cq.size() == 0) chk("conf_unexp", 1, 0);
        else begin
          me = cq.pop_front();
          chk("conf_cyc", cyc, me.cyc);
          chk("pass_data", pass_data, me.data);
          chk("tries", tries, me.tries);
        end
      end else if (cq.size() > 0 && cq[0].cyc <= cyc) begin
        me = cq.pop_front();
        chk("conf_miss", confirm, 1);
      end
      if (request === 1'b1) begin
        if (rq.size() == 0) chk("req_unexp", 1, 0);
        else begin
          me = rq.pop_front();
          chk("req_cyc", cyc, me.cyc);
          chk("din", din, me.data);
        end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        me = rq.pop_front();
        chk("req_miss", request, 1);
      end
      chk("locked", locked, (cyc >= lk_lo && cyc < lk_hi));
    end
  end

  // Press one or both buttons for `hold` cycles; optional unlock_ok on the pulse edge.
  task automatic press(input logic c, input logic r, input logic [3:0] pv, input logic [3:0] dv,
                       input int hold, input logic exp_c, input logic exp_r, input logic ulk);
    int d;
    sw_pass = pv; sw_din = dv;
    btn_confirm = c; btn_request = r;
    d = cyc;
    if (exp_c) begin
      if (ulk) m_tries = 1;
      else if (m_tries < MT) m_tries++;
      cq.push_back('{d + LAT, int'(pv), m_tries});
    end
    if (exp_r) rq.push_back('{d + LAT, int'(dv), 0});
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      unlock_ok = ulk && (cyc == d + LAT - 1);
    end
    btn_confirm = 1'b0; btn_request = 1'b0; unlock_ok = 1'b0;
    step(10);
  endtask

  // Over-limit confirm held through the whole lockout; request pressed inside it.
  task automatic lockout(input logic [3:0] hold_pass, input logic [3:0] hold_din);
    int d;
    btn_confirm = 1'b1; sw_pass = 4'hF;
    d = cyc;
    lk_lo = d + LAT; lk_hi = d + LAT + LK;
    m_tries = 0;
    step(12);
    btn_request = 1'b1; sw_din = 4'hE;
    step(8);
    btn_request = 1'b0;
    step(25);
    chk("tries_after_lock", tries, 0);
    btn_confirm = 1'b0;
    step(10);
    chk("pass_hold_lock", pass_data, hold_pass);
    chk("din_hold_lock", din, hold_din);
  endtask

  initial begin
    int d;
    step(3);
    chk("rst_confirm", confirm, 0);
    chk("rst_request", request, 0);
    chk("rst_locked", locked, 0);
    chk("rst_tries", tries, 0);
    chk("rst_pass", pass_data, 0);
    chk("rst_din", din, 0);
    RST = 1'b1; mon_en = 1'b1;
    step(3);

    press(1, 0, 4'hA, 4'h0, 10, 1, 0, 0);
    chk("pass_hold", pass_data, 4'hA);

    btn_request = 1'b1; sw_din = 4'h3;
    step(2);
    btn_request = 1'b0;
    step(10);
    chk("din_glitch", din, 0);

    press(1, 0, 4'hB, 4'h3, 10, 1, 0, 0);
    press(1, 0, 4'hC, 4'h3, 10, 1, 0, 0);
    lockout(4'hC, 4'h0);

    press(1, 0, 4'h1, 4'h0, 10, 1, 0, 0);
    unlock_ok = 1'b1; step(1); unlock_ok = 1'b0; step(1);
    chk("tries_clr", tries, 0);
    m_tries = 0;

    press(1, 0, 4'h2, 4'h0, 10, 1, 0, 0);
    press(1, 0, 4'h3, 4'h0, 10, 1, 0, 1);
    press(1, 0, 4'h4, 4'h0, 10, 1, 0, 0);
    press(1, 0, 4'h5, 4'h0, 10, 1, 0, 0);
    lockout(4'h5, 4'h0);

    press(1, 1, 4'h6, 4'h9, 10, 1, 1, 0);

    press(1, 0, 4'h2, 4'h9, 10, 1, 0, 0);
    press(1, 0, 4'h3, 4'h9, 10, 1, 0, 0);
    btn_confirm = 1'b1; sw_pass = 4'h7;
    d = cyc;
    lk_lo = d + LAT; lk_hi = d + LAT + LK;
    step(10);
    btn_confirm = 1'b0;
    btn_request = 1'b1; sw_din = 4'h4;
    step(3);
    RST = 1'b0;
    lk_hi = cyc + 1;
    cq.delete(); rq.delete();
    m_tries = 0;
    step(1);
    chk("mid_rst_confirm", confirm, 0);
    chk("mid_rst_request", request, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_tries", tries, 0);
    chk("mid_rst_pass", pass_data, 0);
    chk("mid_rst_din", din, 0);
    RST = 1'b1;
    rq.push_back('{cyc + LAT, 4, 0});
    step(12);
    btn_request = 1'b0;
    step(10);

    press(1, 0, 4'h8, 4'h4, 10, 1, 0, 0);
    step(5);
    chk("pend_conf", cq.size(), 0);
    chk("pend_req", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
